// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and copy-engine state encoding for the data memory path
package mem_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block copy over the single-port data memory (optional fill: MEM_COPY_FILL_EN)
module mem_copy_engine #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import mem_pkg::*;

  copy_state_t       state, state_next;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] data_reg;
  logic              fill_req;
  logic              fill_mode;
  logic              last_word;

`ifdef MEM_COPY_FILL_EN
  assign fill_req = fill;
`else
  assign fill_req  = 1'b0;
  assign fill_mode = 1'b0;
`endif

  assign last_word = (count == (ADDR_W+1)'(1));
  assign mem_wdata = data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Outputs decode from state alone so an async reset drops mem_we at once.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)    state_next = DONE;
          else if (fill_req) state_next = WRITE;
          else              state_next = READ;
        end
      end
      READ: begin
        busy       = 1'b1;
        mem_addr   = src_ptr;
        state_next = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = dst_ptr;
        if (last_word)      state_next = DONE;
        else if (fill_mode) state_next = WRITE;
        else                state_next = READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      count    <= '0;
      data_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            count   <= len;
`ifdef MEM_COPY_FILL_EN
            if (fill) data_reg <= fill_data;
`endif
          end
        end
        READ: data_reg <= mem_rdata;
        WRITE: begin
          src_ptr <= src_ptr + ADDR_W'(1);
          dst_ptr <= dst_ptr + ADDR_W'(1);
          count   <= count - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_COPY_FILL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    fill_mode <= 1'b0;
    else if (state == IDLE && start) fill_mode <= fill;
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard bench for mem_copy_engine (fill case under MEM_COPY_FILL_EN)
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  src_addr, dst_addr;
  logic [10:0] len;
  logic        fill;
  logic [31:0] fill_data;
  logic        busy, done, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  logic [41:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  int edge_no = 0, start_edge = 0;
  int busy_cnt, we_cnt, done_cnt, done_idx;

  localparam logic [31:0] A0 = 32'hA0A0_1000, A1 = 32'hA1A1_1001, A2 = 32'hA2A2_1002, A3 = 32'hA3A3_1003;
  localparam logic [31:0] W = 32'h5757_0001, X = 32'h5858_0002, Y = 32'h5959_0003, Z = 32'h5A5A_0004;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef MEM_COPY_FILL_EN
    .fill(fill), .fill_data(fill_data),
`endif
    .busy(busy), .done(done), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    edge_no++;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected write for every cycle the DUT drives mem_we.
  always @(negedge clk) begin
    logic [41:0] e;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_idx = edge_no - start_edge + 1;
    end
    if (mem_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, none expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e[41:32]));
        chk("wr_data", 64'(mem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic expect_wr(input logic [9:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_start(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l,
                          input logic f, input logic [31:0] fd);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; fill = f; fill_data = fd;
    busy_cnt = 0; we_cnt = 0; done_cnt = 0; done_idx = -1;
    start_edge = edge_no + 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 200 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected one", nm);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    fill = 1'b0; fill_data = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    busy_cnt = 0; we_cnt = 0; done_cnt = 0; done_idx = -1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;

    preload(10'd16, A0); preload(10'd17, A1); preload(10'd18, A2); preload(10'd19, A3);

    // Basic copy
    expect_wr(10'd100, A0); expect_wr(10'd101, A1); expect_wr(10'd102, A2); expect_wr(10'd103, A3);
    do_start(10'd16, 10'd100, 11'd4, 1'b0, 32'h0);
    wait_done("basic");
    chk("basic_done_cycle", 64'(done_idx), 64'd9);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);
    chk("basic_busy_cycles", 64'(busy_cnt), 64'd8);
    chk("basic_we_cycles", 64'(we_cnt), 64'd4);
    chk("basic_mem100", 64'(mem[100]), 64'(A0));
    chk("basic_mem103", 64'(mem[103]), 64'(A3));

    // Zero length
    do_start(10'd16, 10'd100, 11'd0, 1'b0, 32'h0);
    wait_done("zero");
    chk("zero_done_cycle", 64'(done_idx), 64'd1);
    chk("zero_busy_cycles", 64'(busy_cnt), 64'd0);
    chk("zero_we_cycles", 64'(we_cnt), 64'd0);
    chk("zero_mem100", 64'(mem[100]), 64'(A0));

    // Source pointer wrap
    preload(10'd1022, W); preload(10'd1023, X); preload(10'd0, Y); preload(10'd1, Z);
    expect_wr(10'd510, W); expect_wr(10'd511, X); expect_wr(10'd512, Y); expect_wr(10'd513, Z);
    do_start(10'd1022, 10'd510, 11'd4, 1'b0, 32'h0);
    wait_done("wrap_src");
    chk("wrap_src_done_cycle", 64'(done_idx), 64'd9);
    chk("wrap_src_mem512", 64'(mem[512]), 64'(Y));
    chk("wrap_src_mem513", 64'(mem[513]), 64'(Z));

    // Destination pointer wrap
    expect_wr(10'd1023, A0); expect_wr(10'd0, A1);
    do_start(10'd16, 10'd1023, 11'd2, 1'b0, 32'h0);
    wait_done("wrap_dst");
    chk("wrap_dst_done_cycle", 64'(done_idx), 64'd5);
    chk("wrap_dst_mem1023", 64'(mem[1023]), 64'(A0));
    chk("wrap_dst_mem0", 64'(mem[0]), 64'(A1));

    // Start while busy is ignored
    preload(10'd600, 32'h6006_6006);
    expect_wr(10'd300, A0); expect_wr(10'd301, A1); expect_wr(10'd302, A2); expect_wr(10'd303, A3);
    do_start(10'd16, 10'd300, 11'd4, 1'b0, 32'h0);
    @(negedge clk);
    src_addr = 10'd0; dst_addr = 10'd600; len = 11'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("busy_start");
    chk("busy_start_done_cnt", 64'(done_cnt), 64'd1);
    chk("busy_start_done_cycle", 64'(done_idx), 64'd9);
    chk("busy_start_we_cycles", 64'(we_cnt), 64'd4);
    chk("busy_start_mem303", 64'(mem[303]), 64'(A3));
    chk("busy_start_mem600", 64'(mem[600]), 64'h6006_6006);

    // Reset during the third WRITE of an 8-word copy
    preload(10'd20, 32'h2020_2020); preload(10'd21, 32'h2121_2121);
    preload(10'd22, 32'h2222_2222); preload(10'd23, 32'h2323_2323);
    preload(10'd702, 32'h0BAD_0702); preload(10'd703, 32'h0BAD_0703);
    expect_wr(10'd700, A0); expect_wr(10'd701, A1);
    do_start(10'd16, 10'd700, 11'd8, 1'b0, 32'h0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_we", 64'(mem_we), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_we_cycles", 64'(we_cnt), 64'd2);
    chk("midrst_done_cnt", 64'(done_cnt), 64'd0);
    chk("midrst_mem701", 64'(mem[701]), 64'(A1));
    chk("midrst_mem702", 64'(mem[702]), 64'h0BAD_0702);
    chk("midrst_mem703", 64'(mem[703]), 64'h0BAD_0703);
    expect_wr(10'd800, A2);
    do_start(10'd18, 10'd800, 11'd1, 1'b0, 32'h0);
    wait_done("after_rst");
    chk("after_rst_done_cycle", 64'(done_idx), 64'd3);
    chk("after_rst_mem800", 64'(mem[800]), 64'(A2));

`ifdef MEM_COPY_FILL_EN
    expect_wr(10'd200, 32'hDEADBEEF); expect_wr(10'd201, 32'hDEADBEEF); expect_wr(10'd202, 32'hDEADBEEF);
    do_start(10'd16, 10'd200, 11'd3, 1'b1, 32'hDEADBEEF);
    wait_done("fill");
    chk("fill_done_cycle", 64'(done_idx), 64'd4);
    chk("fill_busy_cycles", 64'(busy_cnt), 64'd3);
    chk("fill_we_cycles", 64'(we_cnt), 64'd3);
    chk("fill_mem202", 64'(mem[202]), 64'hDEADBEEF);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
